// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join scheduler: join modes, FSM states and the
// upper bound on the worker count.
package fork_join_pkg;

    typedef enum logic [1:0] {
        JOIN_ALL  = 2'd0,
        JOIN_ANY  = 2'd1,
        JOIN_NONE = 2'd2,
        JOIN_RSVD = 2'd3
    } join_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } fj_state_e;

    localparam int MAX_WORKERS = 16;

endpackage

// File: rtl/fork_join_scheduler.sv
// Launches a set of worker engines on one parent fork and reports completion
// according to join_all / join_any / join_none semantics.
module fork_join_scheduler
    import fork_join_pkg::*;
#(
    parameter int N_WORKERS = 2,
    parameter int ELAPSED_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fork_valid,
    output logic                 fork_ready,
    input  logic [N_WORKERS-1:0] fork_mask,
    input  logic [1:0]           join_mode,
    output logic [N_WORKERS-1:0] worker_start,
    input  logic [N_WORKERS-1:0] worker_done,
    output logic                 join_valid,
    input  logic                 join_ready,
    output logic [N_WORKERS-1:0] join_done_mask,
    output logic [ELAPSED_W-1:0] join_elapsed,
    output logic [N_WORKERS-1:0] outstanding
);

    if (N_WORKERS < 1 || N_WORKERS > MAX_WORKERS) begin : g_bad_n_workers
        $error("fork_join_scheduler: N_WORKERS out of range");
    end

    fj_state_e            state_q, state_d;
    join_mode_e           mode_q;
    logic [N_WORKERS-1:0] mask_q;
    logic [N_WORKERS-1:0] outstanding_q;
    logic [N_WORKERS-1:0] launch_done_q, launch_done_d;
    logic [N_WORKERS-1:0] done_eff;
    logic [ELAPSED_W-1:0] elapsed_q;
    logic                 join_met;
    logic                 fork_accept;

    function automatic logic [ELAPSED_W-1:0] sat_inc(input logic [ELAPSED_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        // Done pulses only count for workers actually in flight.
        done_eff      = worker_done & outstanding_q;
        launch_done_d = launch_done_q | (done_eff & mask_q);

        case (mode_q)
            JOIN_ANY:  join_met = |launch_done_d;
            JOIN_NONE: join_met = 1'b1;
            default:   join_met = (launch_done_d == mask_q);
        endcase

        state_d     = state_q;
        fork_ready  = 1'b0;
        fork_accept = 1'b0;
        case (state_q)
            IDLE: begin
                fork_ready  = ((fork_mask & outstanding_q) == '0);
                fork_accept = fork_valid && fork_ready;
                if (fork_accept) state_d = LAUNCH;
            end
            LAUNCH: begin
                // Nothing to wait on: report straight away with an empty result.
                if (mask_q == '0 || mode_q == JOIN_NONE) state_d = REPORT;
                else                                     state_d = WAIT;
            end
            WAIT:    if (join_met)   state_d = REPORT;
            REPORT:  if (join_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        worker_start   = (state_q == LAUNCH) ? mask_q : '0;
        join_valid     = (state_q == REPORT);
        join_done_mask = join_valid ? launch_done_q : '0;
        join_elapsed   = join_valid ? elapsed_q : '0;
        outstanding    = outstanding_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            launch_done_q <= '0;
            elapsed_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= (outstanding_q & ~done_eff) | worker_start;
            if (state_q == LAUNCH) begin
                launch_done_q <= '0;
                elapsed_q     <= '0;
            end else if (state_q == WAIT) begin
                launch_done_q <= launch_done_d;
                elapsed_q     <= sat_inc(elapsed_q);
            end
        end
    end

    // Fork request payload is only observed after LAUNCH, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fork_accept) begin
            mask_q <= fork_mask;
            mode_q <= join_mode_e'(join_mode);
        end
    end

endmodule

// File: tb/tb_fork_join_scheduler.sv
// Directed bench for fork_join_scheduler; a second instance with a 4-bit
// elapsed counter shares all inputs to exercise saturation.
module tb_fork_join_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fork_valid;
    logic        fork_ready;
    logic [1:0]  fork_mask;
    logic [1:0]  join_mode;
    logic [1:0]  worker_start;
    logic [1:0]  worker_done;
    logic        join_valid;
    logic        join_ready;
    logic [1:0]  join_done_mask;
    logic [15:0] join_elapsed;
    logic [1:0]  outstanding;

    logic        s_fork_ready;
    logic [1:0]  s_worker_start;
    logic        s_join_valid;
    logic [1:0]  s_join_done_mask;
    logic [3:0]  s_join_elapsed;
    logic [1:0]  s_outstanding;

    int checks = 0;
    int errors = 0;

    int          jk, jcnt;
    logic [1:0]  jmask, jmask_s;
    logic [15:0] jel;
    logic [3:0]  jel_s;
    logic        stable_ok;
    logic [1:0]  ost_log [0:99];

    always #5 clk = ~clk;

    fork_join_scheduler #(.N_WORKERS(2), .ELAPSED_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .fork_valid(fork_valid), .fork_ready(fork_ready),
        .fork_mask(fork_mask), .join_mode(join_mode), .worker_start(worker_start),
        .worker_done(worker_done), .join_valid(join_valid), .join_ready(join_ready),
        .join_done_mask(join_done_mask), .join_elapsed(join_elapsed), .outstanding(outstanding)
    );

    fork_join_scheduler #(.N_WORKERS(2), .ELAPSED_W(4)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .fork_valid(fork_valid), .fork_ready(s_fork_ready),
        .fork_mask(fork_mask), .join_mode(join_mode), .worker_start(s_worker_start),
        .worker_done(worker_done), .join_valid(s_join_valid), .join_ready(join_ready),
        .join_done_mask(s_join_done_mask), .join_elapsed(s_join_elapsed), .outstanding(s_outstanding)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a fork for one cycle; returns in the LAUNCH cycle.
    task automatic do_fork(input logic [1:0] m, input logic [1:0] md);
        fork_mask  = m;
        join_mode  = md;
        fork_valid = 1'b1;
        #1;
        check("fork_ready", fork_ready, 1);
        check("fork_ready_sat", s_fork_ready, 1);
        tick();
        fork_valid = 1'b0;
        check("worker_start", worker_start, m);
        check("worker_start_sat", s_worker_start, m);
    endtask

    // k counts cycles from the start pulse; d0/d1 are the done-pulse cycles (-1 = none).
    task automatic run_window(input int d0, input int d1, input int ncyc);
        jk = -1; jcnt = 0; stable_ok = 1'b1;
        for (int k = 0; k < ncyc; k++) begin
            worker_done = {(k == d1), (k == d0)};
            #1;
            ost_log[k] = outstanding;
            if (join_valid) begin
                jcnt++;
                if (jk < 0) begin
                    jk = k; jmask = join_done_mask; jel = join_elapsed;
                    jmask_s = s_join_done_mask; jel_s = s_join_elapsed;
                end else if (join_done_mask != jmask || join_elapsed != jel) begin
                    stable_ok = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end
        worker_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; fork_valid = 1'b0; fork_mask = '0; join_mode = '0;
        worker_done = '0; join_ready = 1'b1;
        #12;
        check("rst_join_valid", join_valid, 0);
        check("rst_worker_start", worker_start, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_done_mask", join_done_mask, 0);
        check("rst_elapsed", join_elapsed, 0);
        rst_n = 1'b1;
        tick();

        // JOIN_ALL, staggered completions
        do_fork(2'b11, 2'd0);
        run_window(20, 30, 40);
        check("t1_join_cycle", jk, 31);
        check("t1_join_count", jcnt, 1);
        check("t1_done_mask", jmask, 2'b11);
        check("t1_elapsed", jel, 30);
        check("t1_elapsed_sat", jel_s, 15);
        check("t1_outst_k1", ost_log[1], 2'b11);
        check("t1_outst_end", outstanding, 0);

        // JOIN_ANY, same stimulus
        do_fork(2'b11, 2'd1);
        run_window(20, 30, 40);
        check("t2_join_cycle", jk, 21);
        check("t2_join_count", jcnt, 1);
        check("t2_done_mask", jmask, 2'b01);
        check("t2_elapsed", jel, 20);
        check("t2_outst_k25", ost_log[25], 2'b10);
        check("t2_outst_k31", ost_log[31], 2'b00);

        // JOIN_NONE with a later overlapping fork held off
        do_fork(2'b11, 2'd2);
        run_window(-1, -1, 3);
        check("t3_join_cycle", jk, 1);
        check("t3_done_mask", jmask, 0);
        check("t3_elapsed", jel, 0);
        check("t3_outst_bg", outstanding, 2'b11);
        fork_mask = 2'b01; join_mode = 2'd0; fork_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_blocked", fork_ready, 0);
            tick();
        end
        worker_done = 2'b01;
        #1;
        check("t3_blocked_done", fork_ready, 0);
        tick();
        worker_done = '0;
        #1;
        check("t3_unblocked", fork_ready, 1);
        check("t3_outst_w1", s_outstanding, 2'b10);
        tick();
        fork_valid = 1'b0;
        check("t3_start2", worker_start, 2'b01);
        run_window(5, -1, 10);
        check("t3_join2_cycle", jk, 6);
        check("t3_join2_mask", jmask, 2'b01);
        check("t3_join2_elapsed", jel, 5);
        do_fork(2'b00, 2'd0);
        run_window(-1, -1, 3);
        check("t3_empty_cycle", jk, 1);
        check("t3_empty_mask", jmask, 0);
        check("t3_empty_elapsed", jel, 0);
        worker_done = 2'b10;
        tick();
        worker_done = '0;
        check("t3_outst_clear", outstanding, 0);

        // Simultaneous dones, report held by back-pressure
        join_ready = 1'b0;
        do_fork(2'b11, 2'd0);
        run_window(5, 5, 16);
        check("t4_join_cycle", jk, 6);
        check("t4_done_mask", jmask, 2'b11);
        check("t4_done_mask_sat", jmask_s, 2'b11);
        check("t4_elapsed", jel, 5);
        check("t4_elapsed_sat", jel_s, 5);
        check("t4_valid_cycles", jcnt, 10);
        check("t4_stable", stable_ok, 1);
        join_ready = 1'b1;
        tick();
        check("t4_valid_drop", join_valid, 0);
        check("t4_mask_drop", join_done_mask, 0);

        // Reset in the middle of WAIT
        do_fork(2'b11, 2'd0);
        run_window(-1, -1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_outst", outstanding, 0);
        check("t5_rst_valid", join_valid, 0);
        check("t5_rst_start", worker_start, 0);
        check("t5_rst_elapsed", join_elapsed, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        do_fork(2'b01, 2'd0);
        run_window(3, -1, 8);
        check("t5_join_cycle", jk, 4);
        check("t5_done_mask", jmask, 2'b01);
        check("t5_elapsed", jel, 3);

        // Spurious dones and reserved mode
        worker_done = 2'b11;
        tick();
        worker_done = '0;
        check("t6_idle_spurious", outstanding, 0);
        do_fork(2'b01, 2'd0);
        run_window(8, 3, 12);
        check("t6_spur_outst", ost_log[4], 2'b01);
        check("t6_spur_cycle", jk, 9);
        check("t6_spur_mask", jmask, 2'b01);
        check("t6_spur_elapsed", jel, 8);
        do_fork(2'b11, 2'd3);
        run_window(10, 25, 30);
        check("t6_rsvd_cycle", jk, 26);
        check("t6_rsvd_mask", jmask, 2'b11);
        check("t6_rsvd_elapsed", jel, 25);
        check("t6_sat_elapsed", jel_s, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
